uart_tx_framer: RTL and testbench
=================================

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 The block SHALL have parameter MaxDataBits, default 8, the maximum data bits per frame; legal range 5..9.
REQ-002 The block SHALL have parameter StopBitsMax, default 2, the maximum stop bits per frame; legal range 1..2.
REQ-003 The block SHALL have a single clock, clk, and reset is asynchronous, active-low, nReset.
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 nReset  input  1  asynchronous active-low reset.
REQ-006 en  input  1  one-clk baud tick from the baud generator; one frame bit lasts one tick.
REQ-007 data  input  MaxDataBits  word to send, LSB first; only bits [cfgDataBits-1:0] are used.
REQ-008 valid  input  1  data is offered.
REQ-009 ready  output  1  holding buffer can accept a word.
REQ-010 cfgDataBits  input  4  data bits per frame.
REQ-011 cfgParity  input  2  parity mode: 0 none, 1 even, 2 odd, 3 none.
REQ-012 cfgStop2  input  1  selects 2 stop bits when 1 and StopBitsMax==2.
REQ-013 out  output  1  serial line, idle high.
REQ-014 busy  output  1  a frame is on the line or a word is held.
REQ-015 done  output  1  one-clk pulse on the en tick that ends the final stop bit.

Function
REQ-016 A transfer SHALL occur on a rising clk edge where valid && ready; it loads data and cfgDataBits/cfgParity/cfgStop2 into a one-entry holding buffer.
REQ-017 ready SHALL equal !holdFull; en SHALL NOT gate acceptance.
REQ-018 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP, and SHALL advance only on clk edges where en=1.
REQ-019 IDLE->START SHALL occur on an en tick with holdFull=1; that edge moves the buffer into the shift register and clears holdFull.
REQ-020 START (out=0) SHALL last 1 tick, then go to DATA.
REQ-021 DATA SHALL last latched cfgDataBits ticks, LSB first, then go to PARITY if parity is enabled, else to STOP.
REQ-022 PARITY SHALL output the XOR of the sent data bits for even mode and its inverse for odd mode, for 1 tick, then go to STOP.
REQ-023 STOP (out=1) SHALL last 1 tick, or 2 ticks when latched cfgStop2=1 and StopBitsMax==2.
REQ-024 On the tick ending STOP, the FSM SHALL go to START if holdFull=1 (no idle gap), else to IDLE; done SHALL pulse on that tick.
REQ-025 out SHALL be registered, SHALL change only on en edges, and SHALL be 1 in IDLE.
REQ-026 A cfgDataBits value outside 5..MaxDataBits SHALL be treated as MaxDataBits.
REQ-027 Configuration changes SHALL take effect only at the next word latch; a frame in progress SHALL use its latched settings.
REQ-028 A word accepted during a frame SHALL be held; valid while holdFull=1 SHALL be ignored, with no overwrite.
REQ-029 If a load into the shift register and a new transfer happen on the same edge, the new word SHALL enter the buffer and holdFull SHALL stay 1.
REQ-030 busy SHALL equal (state!=IDLE) || holdFull.
REQ-031 The bit counter SHALL be 4 bits wide and count down to zero without wrap-around.

Reset
REQ-032 While nReset=0, the block SHALL hold: state=IDLE, out=1, ready=1, busy=0, done=0, holdFull=0, shift register=0, counters=0.
REQ-033 A reset asserted mid-frame SHALL drive out=1 immediately and asynchronously; the frame is abandoned and the held word is discarded.

Configuration
REQ-034 The parity feature SHALL be compiled in only when macro UART_TX_FRAMER_PARITY_EN is defined.
REQ-035 With UART_TX_FRAMER_PARITY_EN defined, REQ-022 applies.
REQ-036 Without UART_TX_FRAMER_PARITY_EN, the PARITY state and parity logic SHALL be absent, cfgParity SHALL be ignored, and frames SHALL always be non-parity.

Verification
REQ-037 The bench SHALL cover: data=0x55, 8N1, en every 4 clks -> out sequence 0,1,0,1,0,1,0,1,0,1 (10 ticks), done on tick 10, ready=1 throughout.
REQ-038 The bench SHALL cover: data=0x07, 7 bits, even parity, cfgStop2=1 -> 0,1,1,1,0,0,0,0,1,1,1 (parity=1), then IDLE.
REQ-039 The bench SHALL cover: two words back-to-back, second sent during the first frame's DATA -> ready=0 until the second START, and no idle tick between the STOP and the second START.
REQ-040 The bench SHALL cover: cfgDataBits=12 with MaxDataBits=8 -> 8 data bits sent.
REQ-041 The bench SHALL cover: nReset pulsed during the DATA of 0x00 -> out=1 in the same cycle, busy=0, and the next accepted word frames correctly.
REQ-042 The bench SHALL cover: build without UART_TX_FRAMER_PARITY_EN, cfgParity=2, data=0xFF 8 bits -> 10-tick frame with no parity bit.

Source files
------------

// File: rtl/uart_tx_framer.sv
// UART transmit framer: one-entry holding buffer feeding a start/data/parity/stop serialiser.
// Parity is compiled in only when UART_TX_FRAMER_PARITY_EN is defined.
module uart_tx_framer #(
  parameter int MaxDataBits = 8,
  parameter int StopBitsMax = 2
) (
  input  logic                   clk,
  input  logic                   nReset,
  input  logic                   en,
  input  logic [MaxDataBits-1:0] data,
  input  logic                   valid,
  output logic                   ready,
  input  logic [3:0]             cfgDataBits,
  input  logic [1:0]             cfgParity,
  input  logic                   cfgStop2,
  output logic                   out,
  output logic                   busy,
  output logic                   done
);

`ifdef UART_TX_FRAMER_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  localparam logic [3:0] MAX_BITS = 4'(MaxDataBits);

  state_t                 state_q, state_n;
  logic                   out_q, out_n;
  logic [3:0]             cnt_q, cnt_n;
  logic [MaxDataBits-1:0] shift_q, shift_n;
  logic                   load;
  logic                   frame_end;

  logic                   hold_full_q;
  logic [MaxDataBits-1:0] hold_data_q;
  logic [3:0]             hold_bits_q;
  logic                   hold_stop2_q;
  logic [3:0]             frame_bits_q;
  logic                   frame_stop2_q;

  logic                   accept;
  logic [3:0]             eff_bits;

  assign accept   = valid && !hold_full_q;
  assign eff_bits = (cfgDataBits < 4'd5 || cfgDataBits > MAX_BITS) ? MAX_BITS : cfgDataBits;

`ifdef UART_TX_FRAMER_PARITY_EN
  logic par_calc;
  logic hold_par_en_q, hold_par_bit_q;
  logic frame_par_en_q, frame_par_bit_q;

  // Parity is resolved when the word is accepted, over only the bits that will be sent
  always_comb begin
    par_calc = 1'b0;
    for (int i = 0; i < MaxDataBits; i++) begin
      if (4'(i) < eff_bits) par_calc = par_calc ^ data[i];
    end
  end
`else
  logic unused_cfg_parity;
  assign unused_cfg_parity = ^cfgParity;
`endif

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
      out_q   <= 1'b1;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_n;
      out_q   <= out_n;
      cnt_q   <= cnt_n;
      shift_q <= shift_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    out_n     = out_q;
    cnt_n     = cnt_q;
    shift_n   = shift_q;
    load      = 1'b0;
    frame_end = 1'b0;
    if (en) begin
      case (state_q)
        IDLE: begin
          if (hold_full_q) begin
            state_n = START;
            out_n   = 1'b0;
            shift_n = hold_data_q;
            load    = 1'b1;
          end
        end
        START: begin
          state_n = DATA;
          out_n   = shift_q[0];
          shift_n = shift_q >> 1;
          cnt_n   = frame_bits_q - 4'd1;
        end
        DATA: begin
          if (cnt_q != 4'd0) begin
            out_n   = shift_q[0];
            shift_n = shift_q >> 1;
            cnt_n   = cnt_q - 4'd1;
          end else begin
`ifdef UART_TX_FRAMER_PARITY_EN
            if (frame_par_en_q) begin
              state_n = PARITY;
              out_n   = frame_par_bit_q;
            end else begin
              state_n = STOP;
              out_n   = 1'b1;
              cnt_n   = frame_stop2_q ? 4'd1 : 4'd0;
            end
`else
            state_n = STOP;
            out_n   = 1'b1;
            cnt_n   = frame_stop2_q ? 4'd1 : 4'd0;
`endif
          end
        end
`ifdef UART_TX_FRAMER_PARITY_EN
        PARITY: begin
          state_n = STOP;
          out_n   = 1'b1;
          cnt_n   = frame_stop2_q ? 4'd1 : 4'd0;
        end
`endif
        STOP: begin
          if (cnt_q != 4'd0) begin
            cnt_n = cnt_q - 4'd1;
          end else begin
            frame_end = 1'b1;
            // A held word starts immediately so back-to-back frames have no idle gap
            if (hold_full_q) begin
              state_n = START;
              out_n   = 1'b0;
              shift_n = hold_data_q;
              load    = 1'b1;
            end else begin
              state_n = IDLE;
              out_n   = 1'b1;
            end
          end
        end
        default: begin
          state_n = IDLE;
          out_n   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      hold_full_q   <= 1'b0;
      hold_data_q   <= '0;
      hold_bits_q   <= '0;
      hold_stop2_q  <= 1'b0;
      frame_bits_q  <= '0;
      frame_stop2_q <= 1'b0;
    end else begin
      if (load) begin
        frame_bits_q  <= hold_bits_q;
        frame_stop2_q <= hold_stop2_q;
      end
      if (accept) begin
        hold_full_q  <= 1'b1;
        hold_data_q  <= data;
        hold_bits_q  <= eff_bits;
        hold_stop2_q <= cfgStop2 && (StopBitsMax == 2);
      end else if (load) begin
        hold_full_q <= 1'b0;
      end
    end
  end

`ifdef UART_TX_FRAMER_PARITY_EN
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      hold_par_en_q   <= 1'b0;
      hold_par_bit_q  <= 1'b0;
      frame_par_en_q  <= 1'b0;
      frame_par_bit_q <= 1'b0;
    end else begin
      if (load) begin
        frame_par_en_q  <= hold_par_en_q;
        frame_par_bit_q <= hold_par_bit_q;
      end
      if (accept) begin
        hold_par_en_q  <= (cfgParity == 2'd1) || (cfgParity == 2'd2);
        hold_par_bit_q <= par_calc ^ (cfgParity == 2'd2);
      end
    end
  end
`endif

  assign ready = !hold_full_q;
  assign busy  = (state_q != IDLE) || hold_full_q;
  assign done  = frame_end;
  assign out   = out_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed and randomized bench for uart_tx_framer; expected line levels come from a frame-building model.
module tb_uart_tx_framer;

  localparam int MAXB    = 8;
  localparam int STOPMAX = 2;

  logic       clk = 1'b0;
  logic       nReset = 1'b0;
  logic       en = 1'b0;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0;
  logic [3:0] cfgDataBits = 4'd8;
  logic [1:0] cfgParity = 2'd0;
  logic       cfgStop2 = 1'b0;
  logic       ready, out, busy, done;

  int passed = 0;
  int total  = 0;
  int en_gap = 4;

  bit exp_q[$];
  int frame_ends[$];

  logic [7:0] pend_data;
  int         pend_bits;
  int         pend_par;
  bit         pend_stop2;

  always #5 clk = ~clk;

  uart_tx_framer #(.MaxDataBits(MAXB), .StopBitsMax(STOPMAX)) dut (
    .clk(clk), .nReset(nReset), .en(en), .data(data), .valid(valid), .ready(ready),
    .cfgDataBits(cfgDataBits), .cfgParity(cfgParity), .cfgStop2(cfgStop2),
    .out(out), .busy(busy), .done(done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Offers one word, then scrambles the config inputs so latched settings must be used
  task automatic applyStimulus(input logic [7:0] d, input int bits, input int par, input bit stop2);
    data        = d;
    cfgDataBits = 4'(bits);
    cfgParity   = 2'(par);
    cfgStop2    = stop2;
    valid       = 1'b1;
    @(negedge clk);
    valid       = 1'b0;
    data        = 8'($urandom);
    cfgDataBits = 4'($urandom);
    cfgParity   = 2'($urandom);
    cfgStop2    = 1'($urandom);
  endtask

  task automatic appendFrame(input logic [7:0] d, input int bits, input int par, input bit stop2);
    int n;
    int ones;
    n    = (bits < 5 || bits > MAXB) ? MAXB : bits;
    ones = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(d[i]);
      ones += int'(d[i]);
    end
`ifdef UART_TX_FRAMER_PARITY_EN
    if (par == 1) exp_q.push_back(bit'(ones % 2));
    else if (par == 2) exp_q.push_back(bit'(1 - ones % 2));
`endif
    exp_q.push_back(1'b1);
    if (stop2 && STOPMAX == 2) exp_q.push_back(1'b1);
    frame_ends.push_back(exp_q.size());
  endtask

  function automatic bit isEnd(input int k);
    foreach (frame_ends[i]) if (frame_ends[i] == k) return 1'b1;
    return 1'b0;
  endfunction

  task automatic enTick(output bit done_seen);
    repeat (en_gap - 1) @(negedge clk);
    en = 1'b1;
    #1 done_seen = done;
    @(negedge clk);
    en = 1'b0;
  endtask

  // Plays every en edge of the queued frames; optionally injects the pending word after edge 'inject'
  task automatic playStream(input string name, input int inject, input bit extra_try);
    bit ds;
    bit exp_out;
    int first_end;
    int n;
    first_end = frame_ends[0];
    n = exp_q.size();
    for (int k = 0; k <= n; k++) begin
      enTick(ds);
      exp_out = (k < n) ? exp_q[k] : 1'b1;
      checkOutput($sformatf("%s out@%0d", name, k), out, exp_out);
      checkOutput($sformatf("%s done@%0d", name, k), ds, isEnd(k));
      checkOutput($sformatf("%s ready@%0d", name, k), ready,
                  !(inject >= 0 && k > inject && k < first_end));
      checkOutput($sformatf("%s busy@%0d", name, k), busy, k < n);
      if (k == inject) begin
        applyStimulus(pend_data, pend_bits, pend_par, pend_stop2);
        checkOutput($sformatf("%s ready_held", name), ready, 1'b0);
        if (extra_try) applyStimulus(~pend_data, 8, 0, 1'b0);
      end
    end
    exp_q.delete();
    frame_ends.delete();
  endtask

  initial begin
    bit ds;
    logic [7:0] d;
    int bits, par, inj;
    bit s2;

    repeat (2) @(negedge clk);
    checkOutput("reset out", out, 1'b1);
    checkOutput("reset ready", ready, 1'b1);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset done", done, 1'b0);
    nReset = 1'b1;
    @(negedge clk);

    en_gap = 4;
    applyStimulus(8'h55, 8, 0, 1'b0);
    checkOutput("held busy", busy, 1'b1);
    appendFrame(8'h55, 8, 0, 1'b0);
    playStream("8n1_55", -1, 1'b0);

    applyStimulus(8'h07, 7, 1, 1'b1);
    appendFrame(8'h07, 7, 1, 1'b1);
    playStream("7e2_07", -1, 1'b0);

    en_gap = 2;
    applyStimulus(8'hA3, 8, 0, 1'b0);
    appendFrame(8'hA3, 8, 0, 1'b0);
    pend_data = 8'h3C; pend_bits = 6; pend_par = 2; pend_stop2 = 1'b1;
    appendFrame(pend_data, pend_bits, pend_par, pend_stop2);
    playStream("b2b", 3, 1'b1);

    applyStimulus(8'hC6, 12, 0, 1'b0);
    appendFrame(8'hC6, 12, 0, 1'b0);
    playStream("clamp12", -1, 1'b0);

    applyStimulus(8'hFF, 8, 2, 1'b0);
    appendFrame(8'hFF, 8, 2, 1'b0);
    playStream("odd_ff", -1, 1'b0);

    en_gap = 3;
    applyStimulus(8'h00, 8, 0, 1'b0);
    repeat (3) enTick(ds);
    checkOutput("rst mid data out", out, 1'b0);
    applyStimulus(8'h99, 8, 0, 1'b0);
    nReset = 1'b0;
    #1;
    checkOutput("rst async out", out, 1'b1);
    checkOutput("rst async busy", busy, 1'b0);
    checkOutput("rst async ready", ready, 1'b1);
    checkOutput("rst async done", done, 1'b0);
    @(negedge clk);
    nReset = 1'b1;
    @(negedge clk);
    applyStimulus(8'hA5, 8, 1, 1'b0);
    appendFrame(8'hA5, 8, 1, 1'b0);
    playStream("after_rst", -1, 1'b0);

    for (int r = 0; r < 8; r++) begin
      en_gap = $urandom_range(1, 5);
      d    = 8'($urandom);
      bits = $urandom_range(0, 15);
      par  = $urandom_range(0, 3);
      s2   = 1'($urandom);
      applyStimulus(d, bits, par, s2);
      appendFrame(d, bits, par, s2);
      inj = -1;
      if (r % 2 == 1) begin
        pend_data  = 8'($urandom);
        pend_bits  = $urandom_range(0, 15);
        pend_par   = $urandom_range(0, 3);
        pend_stop2 = 1'($urandom);
        inj = $urandom_range(0, frame_ends[0] - 1);
        appendFrame(pend_data, pend_bits, pend_par, pend_stop2);
      end
      playStream($sformatf("rand%0d", r), inj, r % 4 == 1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
